// File: rtl/pipeline_stage_buffer_pkg.sv
// Shared definitions for generic pipeline-stage buffers: default sizes,
// per-stage packed payload layouts and pointer-wrap helper.
package pipeline_stage_buffer_pkg;

   localparam int PIPE_BUF_DEPTH_DEFAULT = 2;
   localparam int PIPE_STALL_CNT_WIDTH   = 16;

   // EX/MEM fields packed into one payload vector, msb first.
   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
      logic [4:0]  rd_addr;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic [2:0]  mem_size;
   } exmem_payload_t;

   localparam int EXMEM_PAYLOAD_WIDTH = $bits(exmem_payload_t);

   typedef struct packed {
      logic [31:0] wb_data;
      logic [4:0]  rd_addr;
      logic        reg_write;
   } memwb_payload_t;

   localparam int MEMWB_PAYLOAD_WIDTH = $bits(memwb_payload_t);

   // Per-edge queue operation, encoded as {push, pop}.
   typedef enum logic [1:0] {
      BUF_IDLE = 2'b00,
      BUF_POP  = 2'b01,
      BUF_PUSH = 2'b10,
      BUF_BOTH = 2'b11
   } buf_op_e;

   // Explicit compare-to-last wrap so non-power-of-2 depths work.
   function automatic int ptr_wrap_inc(input int ptr, input int depth);
      return (ptr >= depth - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/pipeline_stage_buffer_storage.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module pipeline_stage_storage #(
   parameter int DATA_WIDTH = 64,
   parameter int DEPTH      = 2,
   parameter int ADDR_W     = 1
)(
   input  logic                  i_clk,
   input  logic                  i_we,
   input  logic [ADDR_W-1:0]     i_waddr,
   input  logic [DATA_WIDTH-1:0] i_wdata,
   input  logic [ADDR_W-1:0]     i_raddr,
   output logic [DATA_WIDTH-1:0] o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pipeline_stage_buffer.sv
// Generic pipeline-stage buffer: valid/ready handshake, synchronous flush,
// DEPTH-entry queue and a saturating stall-event counter.
module pipeline_stage_buffer
   import pipeline_stage_buffer_pkg::*;
#(
   parameter int                    DATA_WIDTH  = 64,
   parameter int                    DEPTH       = PIPE_BUF_DEPTH_DEFAULT,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
   parameter int                    CNT_WIDTH   = PIPE_STALL_CNT_WIDTH
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush_in,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [CNT_WIDTH-1:0]         stall_events,
   input  logic                         stall_events_clr
);

   localparam int OCC_W = $clog2(DEPTH + 1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

   logic [OCC_W-1:0]      r_count;
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_stall_cnt;

   logic                  w_push;
   logic                  w_pop;
   logic                  w_we;
   logic                  w_stall_evt;
   buf_op_e               w_op;
   logic [OCC_W-1:0]      w_count_nxt;
   logic [PTR_W-1:0]      w_wr_ptr_nxt;
   logic [PTR_W-1:0]      w_rd_ptr_nxt;
   logic [PTR_W-1:0]      w_wr_ptr_inc;
   logic [PTR_W-1:0]      w_rd_ptr_inc;
   logic [CNT_WIDTH-1:0]  w_stall_nxt;
   logic [DATA_WIDTH-1:0] w_rdata;

   // Handshake: a transfer happens on an edge where valid && ready are both 1.
   // Both ready and valid come only from registered state, so there is no
   // combinational out_ready -> in_ready path; a full buffer admits a new
   // entry only on the cycle after a pop.
   assign in_ready  = (r_count < FULL_CNT);
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;
   assign w_op      = buf_op_e'({w_push, w_pop});
   assign w_we      = w_push & ~flush_in;

   assign w_wr_ptr_inc = PTR_W'(ptr_wrap_inc(32'(r_wr_ptr), DEPTH));
   assign w_rd_ptr_inc = PTR_W'(ptr_wrap_inc(32'(r_rd_ptr), DEPTH));

   always_comb begin
      w_count_nxt  = r_count;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (flush_in) begin
         w_count_nxt  = '0;
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
      end else begin
         case (w_op)
            BUF_PUSH: begin
               w_wr_ptr_nxt = w_wr_ptr_inc;
               w_count_nxt  = r_count + OCC_W'(1);
            end
            BUF_POP: begin
               w_rd_ptr_nxt = w_rd_ptr_inc;
               w_count_nxt  = r_count - OCC_W'(1);
            end
            BUF_BOTH: begin
               w_wr_ptr_nxt = w_wr_ptr_inc;
               w_rd_ptr_nxt = w_rd_ptr_inc;
            end
            default: begin
            end
         endcase
      end
   end

   // Clear wins over increment; flush leaves the counter alone.
   assign w_stall_evt = in_valid & ~in_ready;

   always_comb begin
      w_stall_nxt = r_stall_cnt;
      if (stall_events_clr) begin
         w_stall_nxt = '0;
      end else if (w_stall_evt && (r_stall_cnt != '1)) begin
         w_stall_nxt = r_stall_cnt + CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count     <= '0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_count     <= w_count_nxt;
         r_wr_ptr    <= w_wr_ptr_nxt;
         r_rd_ptr    <= w_rd_ptr_nxt;
         r_stall_cnt <= w_stall_nxt;
      end
   end

   pipeline_stage_storage #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_W     (PTR_W)
   ) u_storage (
      .i_clk   (clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr),
      .i_wdata (in_data),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   assign out_data     = out_valid ? w_rdata : RESET_VALUE;
   assign occupancy    = r_count;
   assign stall_events = r_stall_cnt;

   a_count_bound: assert property (@(posedge clk) disable iff (!rst)
      r_count <= FULL_CNT);

   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
      (r_count == FULL_CNT) |-> !w_push);

endmodule
